// File: rtl/slave_stream_s00_axis.sv
// AXI4-Stream ingress slave: lands beats (with TLAST) into an external write-side FIFO
// through a two-entry head/skid buffer so that S_AXIS_TREADY comes straight from a flop.
module slave_stream_s00_axis #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_CNT_WIDTH          = 16
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESET,
    input  logic                            S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH:0]   fifo_din,
    output logic                            fifo_wr_en,
    input  logic                            fifo_full,
    output logic [C_CNT_WIDTH-1:0]          beat_count,
    output logic [C_CNT_WIDTH-1:0]          pkt_count
);

    localparam int W = C_S_AXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [W:0]             head_q, head_d;
    logic [W:0]             skid_q, skid_d;
    logic                   tready_q, tready_d;
    logic [C_CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [C_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    logic       accept;
    logic       write;
    logic [W:0] beat;

    assign beat   = {S_AXIS_TLAST, S_AXIS_TDATA};
    assign accept = S_AXIS_TVALID & tready_q & ~S_AXIS_ARESET;
    // Suppressing the strobe during reset keeps held beats from leaking into the FIFO.
    assign write  = (state_q != ST_EMPTY) & ~fifo_full & ~S_AXIS_ARESET;

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        skid_d       = skid_q;
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = beat;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && write) begin
                    head_d = beat;
                end else if (accept) begin
                    skid_d  = beat;
                    state_d = ST_FULL;
                end else if (write) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (write) begin
                    head_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (accept) begin
            beat_count_d = beat_count_q + 1'b1;
            if (S_AXIS_TLAST) begin
                pkt_count_d = pkt_count_q + 1'b1;
            end
        end

        // Ready looks one state ahead so it can drop on the very edge the skid fills.
        tready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q      <= ST_EMPTY;
            head_q       <= '0;
            skid_q       <= '0;
            tready_q     <= 1'b0;
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            tready_q     <= tready_d;
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign fifo_din      = head_q;
    assign fifo_wr_en    = write;
    assign beat_count    = beat_count_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_slave_stream_s00_axis.sv
// Directed bench for slave_stream_s00_axis: vector table for streaming/packets, hand
// sequences for backpressure, counter wrap and reset-while-full, plus an order scoreboard.
module tb_slave_stream_s00_axis;

    logic        clk;
    logic        areset;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        fifo_full;

    logic        tready;
    logic [32:0] fifo_din;
    logic        fifo_wr_en;
    logic [15:0] beat_count;
    logic [15:0] pkt_count;

    logic        tready4;
    logic [32:0] fifo_din4;
    logic        fifo_wr_en4;
    logic [3:0]  beat_count4;
    logic [3:0]  pkt_count4;

    int total;
    int bad;

    logic [32:0] sb[$];
    int          occ;
    logic [15:0] exp_beat;
    logic [15:0] exp_pkt;

    slave_stream_s00_axis #(.C_S_AXIS_TDATA_WIDTH(32), .C_CNT_WIDTH(16)) u_dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (areset),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count)
    );

    slave_stream_s00_axis #(.C_S_AXIS_TDATA_WIDTH(32), .C_CNT_WIDTH(4)) u_dut4 (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (areset),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready4),
        .fifo_din      (fifo_din4),
        .fifo_wr_en    (fifo_wr_en4),
        .fifo_full     (fifo_full),
        .beat_count    (beat_count4),
        .pkt_count     (pkt_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        exp_wr;
        logic [32:0] exp_din;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Runs on every falling edge: sees what the next rising edge will accept/write.
    task automatic monitor();
        logic [32:0] exp_word;
        forever begin
            @(negedge clk);
            if (areset) begin
                sb.delete();
                occ      = 0;
                exp_beat = '0;
                exp_pkt  = '0;
            end else begin
                if (occ == 2) begin
                    check("full_tready_low", {63'd0, tready}, 64'd0);
                end
                if (fifo_wr_en) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow_write", 64'd1, 64'd0);
                    end else begin
                        exp_word = sb.pop_front();
                        check("sb_order", {31'd0, fifo_din}, {31'd0, exp_word});
                    end
                    occ--;
                end
                if (tvalid && tready) begin
                    sb.push_back({tlast, tdata});
                    occ++;
                    exp_beat = exp_beat + 16'd1;
                    if (tlast) exp_pkt = exp_pkt + 16'd1;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        @(posedge clk);
        #1;
        tvalid = v;
        tdata  = d;
        tlast  = l;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l,
                                input logic exp_wr, input logic [32:0] exp_din);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.exp_wr = exp_wr; r.exp_din = exp_din;
        return r;
    endfunction

    initial begin
        int wr_seen;
        total     = 0;
        bad       = 0;
        occ       = 0;
        exp_beat  = '0;
        exp_pkt   = '0;
        areset    = 1'b1;
        tvalid    = 1'b1;
        tdata     = 32'hDEAD_BEEF;
        tlast     = 1'b0;
        fifo_full = 1'b0;

        fork
            monitor();
        join_none

        // 8 back-to-back beats, then a 3-beat packet ending in TLAST
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1'b1, 32'(i + 1), 1'b0, (i != 0), {1'b0, 32'(i)});
        end
        vecs[8]  = mk(1'b0, 32'h0,  1'b0, 1'b1, {1'b0, 32'h8});
        vecs[9]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 33'h0);
        vecs[10] = mk(1'b1, 32'h10, 1'b0, 1'b0, 33'h0);
        vecs[11] = mk(1'b1, 32'h11, 1'b0, 1'b1, {1'b0, 32'h10});
        vecs[12] = mk(1'b1, 32'h12, 1'b1, 1'b1, {1'b0, 32'h11});
        vecs[13] = mk(1'b0, 32'h0,  1'b0, 1'b1, {1'b1, 32'h12});
        vecs[14] = mk(1'b0, 32'h0,  1'b0, 1'b0, 33'h0);

        // Reset held three cycles with TVALID asserted
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_tready", {63'd0, tready}, 64'd0);
            check("rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        end
        check("rst_din", {31'd0, fifo_din}, 64'd0);
        check("rst_beat_count", {48'd0, beat_count}, 64'd0);
        check("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        tvalid = 1'b0;
        @(negedge clk);
        check("rel_tready_before_edge", {63'd0, tready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rel_tready_after_edge", {63'd0, tready}, 64'd1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l);
            check($sformatf("vec%0d_tready", i), {63'd0, tready}, 64'd1);
            check($sformatf("vec%0d_wr_en", i), {63'd0, fifo_wr_en}, {63'd0, vecs[i].exp_wr});
            if (vecs[i].exp_wr) begin
                check($sformatf("vec%0d_din", i), {31'd0, fifo_din}, {31'd0, vecs[i].exp_din});
            end
        end
        check("tbl_beat_count", {48'd0, beat_count}, 64'd11);
        check("tbl_pkt_count", {48'd0, pkt_count}, 64'd1);

        // Backpressure: two beats fill head+skid while the FIFO is full
        fifo_full = 1'b1;
        drive(1'b1, 32'hA, 1'b0);
        check("bp_accept_a", {63'd0, tready}, 64'd1);
        drive(1'b1, 32'hB, 1'b0);
        check("bp_accept_b", {63'd0, tready}, 64'd1);
        drive(1'b0, 32'h0, 1'b0);
        check("bp_full_tready", {63'd0, tready}, 64'd0);
        check("bp_full_no_wr", {63'd0, fifo_wr_en}, 64'd0);
        drive(1'b1, 32'hEE, 1'b1);
        check("bp_ignored_tready", {63'd0, tready}, 64'd0);
        check("bp_ignored_no_wr", {63'd0, fifo_wr_en}, 64'd0);
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        tvalid    = 1'b0;
        @(negedge clk);
        check("bp_wr_a", {63'd0, fifo_wr_en}, 64'd1);
        check("bp_din_a", {31'd0, fifo_din}, 64'hA);
        check("bp_tready_during_a", {63'd0, tready}, 64'd0);
        drive(1'b0, 32'h0, 1'b0);
        check("bp_wr_b", {63'd0, fifo_wr_en}, 64'd1);
        check("bp_din_b", {31'd0, fifo_din}, 64'hB);
        check("bp_tready_after_a", {63'd0, tready}, 64'd1);
        drive(1'b0, 32'h0, 1'b0);
        check("bp_drained", {63'd0, fifo_wr_en}, 64'd0);
        check("bp_beat_count", {48'd0, beat_count}, 64'd13);
        check("bp_beat_model", {48'd0, beat_count}, {48'd0, exp_beat});

        // Counter wrap: 17 beats, TLAST on the 8th and 17th
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 32'h100 + 32'(i), (i == 8) || (i == 17));
        end
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        check("wrap4_beat_count", {60'd0, beat_count4}, 64'd1);
        check("wrap4_pkt_count", {60'd0, pkt_count4}, 64'd2);
        check("wrap16_beat_count", {48'd0, beat_count}, 64'd17);
        check("wrap16_pkt_count", {48'd0, pkt_count}, {48'd0, exp_pkt});

        // Reset while FULL: held beats 0xC/0xD must never be written
        fifo_full = 1'b1;
        drive(1'b1, 32'hC, 1'b0);
        drive(1'b1, 32'hD, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        check("rf_full_tready", {63'd0, tready}, 64'd0);
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(negedge clk);
        check("rf_wr_gated", {63'd0, fifo_wr_en}, 64'd0);
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        @(negedge clk);
        check("rf_rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        check("rf_rst_din", {31'd0, fifo_din}, 64'd0);
        check("rf_rst_tready", {63'd0, tready}, 64'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (fifo_wr_en) wr_seen++;
        end
        check("rf_no_writes", 64'(wr_seen), 64'd0);
        check("rf_tready_back", {63'd0, tready}, 64'd1);
        check("rf_beat_count", {48'd0, beat_count}, 64'd0);
        check("rf_pkt_count", {48'd0, pkt_count}, 64'd0);
        check("sb_empty_at_end", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
